// File: rtl/difference_collector_pkg.sv
// Shared Capstone definitions for the serial
// collector and serial-adder controller.
package difference_collector_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/difference_collector_bit_counter.sv
// Saturating bit counter, 0 .. WIDTH-1,
// with synchronous clear and terminal count.
module bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  assign tc = (cnt == LAST);

  // count up on enable, hold at the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/difference_collector.sv
// Deserialises an LSB-first subtractor stream
// into a parallel word plus final borrow.
module difference_collector
  import difference_collector_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Start,
  input  logic             Sin,
  input  logic             Cin,
  output logic [WIDTH-1:0] Dout,
  output logic             Bout,
  output logic             Valid,
  output logic             Busy
);

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] shifted;
  logic             tc;
  logic             sample;
  logic             last;

  assign shifted = {Sin, work[WIDTH-1:1]};
  assign sample  = (state == SHIFT) && !Start;
  assign last    = sample && tc;

  bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (CLK),
    .rst_n(RSTn),
    .clr  (Start),
    .en   (sample),
    .tc   (tc)
  );

  // state register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // next state; Start always (re)opens a frame
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = Start ? SHIFT : IDLE;
      SHIFT: begin
        if (Start) begin
          nxt = SHIFT;
        end else if (tc) begin
          nxt = DONE;
        end else begin
          nxt = SHIFT;
        end
      end
      DONE:    nxt = Start ? SHIFT : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // status outputs decoded from registered state
  always_comb begin
    Busy  = (state == SHIFT);
    Valid = (state == DONE);
  end

  // working shift register, cleared on Start
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      work <= '0;
    end else if (Start) begin
      work <= '0;
    end else if (sample) begin
      work <= shifted;
    end
  end

  // result registers load only on a finished frame
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Dout <= '0;
      Bout <= 1'b0;
    end else if (last) begin
      Dout <= shifted;
      Bout <= Cin;
    end
  end

endmodule

// File: tb/tb_difference_collector.sv
// Directed bench for difference_collector,
// WIDTH=8 and WIDTH=4 instances.
module tb_difference_collector;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       Start, Sin, Cin;
  logic [7:0] Dout;
  logic       Bout, Valid, Busy;

  logic       s4, i4, c4;
  logic [3:0] d4;
  logic       b4, v4, y4;

  int comps = 0;
  int errs  = 0;

  always #5 CLK = ~CLK;

  difference_collector #(.WIDTH(8)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .Start(Start),
    .Sin  (Sin),
    .Cin  (Cin),
    .Dout (Dout),
    .Bout (Bout),
    .Valid(Valid),
    .Busy (Busy)
  );

  difference_collector #(.WIDTH(4)) dut4 (
    .CLK  (CLK),
    .RSTn (RSTn),
    .Start(s4),
    .Sin  (i4),
    .Cin  (c4),
    .Dout (d4),
    .Bout (b4),
    .Valid(v4),
    .Busy (y4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    comps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input logic st,
                      input logic si,
                      input logic ci);
    Start = st;
    Sin   = si;
    Cin   = ci;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string tag,
                         input logic [7:0] d,
                         input logic b,
                         input logic v,
                         input logic y);
    chk({tag, "_dout"},  32'(Dout),  32'(d));
    chk({tag, "_bout"},  32'(Bout),  32'(b));
    chk({tag, "_valid"}, 32'(Valid), 32'(v));
    chk({tag, "_busy"},  32'(Busy),  32'(y));
  endtask

  // eight LSB-first bits; Cin is the inverse of
  // c except on the final bit
  task automatic send(input string tag,
                      input logic [7:0] d,
                      input logic c,
                      input logic [7:0] pd,
                      input logic pb);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, d[i], (i == 7) ? c : ~c);
      if (i < 7) begin
        chk_out({tag, "_mid"}, pd, pb, 1'b0, 1'b1);
      end
    end
    chk_out({tag, "_end"}, d, c, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    RSTn  = 1'b0;
    Start = 1'b0;
    Sin   = 1'b0;
    Cin   = 1'b0;
    s4    = 1'b0;
    i4    = 1'b0;
    c4    = 1'b0;
    #2;
    chk_out("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_valid4", 32'(v4), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;

    // frame 5B, borrow 1, Start at edge 1
    step(1'b1, 1'b0, 1'b0);
    chk_out("f1_start", 8'h00, 1'b0, 1'b0, 1'b1);
    send("f1", 8'h5B, 1'b1, 8'h00, 1'b0);

    // back-to-back: Start in DONE cycle
    step(1'b1, 1'b1, 1'b1);
    chk_out("f2_start", 8'h5B, 1'b1, 1'b0, 1'b1);
    send("f2", 8'hA4, 1'b0, 8'h5B, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk_out("f2_idle", 8'hA4, 1'b0, 1'b0, 1'b0);

    // abort after four bits, then 3C
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1);
      chk_out("ab_part", 8'hA4, 1'b0, 1'b0, 1'b1);
    end
    step(1'b1, 1'b1, 1'b1);
    chk_out("ab_restart", 8'hA4, 1'b0, 1'b0, 1'b1);
    send("ab", 8'h3C, 1'b1, 8'hA4, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_out("ab_idle", 8'h3C, 1'b1, 1'b0, 1'b0);

    // inputs toggling while idle
    for (int i = 0; i < 20; i++) begin
      step(1'b0, i[0], ~i[1]);
      chk_out("idle_tog", 8'h3C, 1'b1, 1'b0, 1'b0);
    end

    // async reset mid-frame
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1);
    end
    #2;
    RSTn = 1'b0;
    #1;
    chk_out("mrst", 8'h00, 1'b0, 1'b0, 1'b0);
    #2;
    RSTn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b1);
      chk_out("mrst_post", 8'h00, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0);
    send("ff", 8'hFF, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // WIDTH=4 instance: bits 1,0,0,1 -> 9
    s4 = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("w4_busy", 32'(y4), 32'd1);
    s4 = 1'b0;
    i4 = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    i4 = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("w4_novalid", 32'(v4), 32'd0);
    chk("w4_hold", 32'(d4), 32'h0);
    i4 = 1'b1;
    c4 = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("w4_valid", 32'(v4), 32'd1);
    chk("w4_dout", 32'(d4), 32'h9);
    chk("w4_bout", 32'(b4), 32'd1);
    chk("w4_busy_end", 32'(y4), 32'd0);
    i4 = 1'b0;
    c4 = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk("w4_pulse", 32'(v4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             comps, errs);
    $finish;
  end

endmodule
